// File: rtl/spi_rxc.sv
// SPI receive core: deserialises N-bit frames (8/16/32) with optional CRC-frame checking.
// rx_data/rx_valid register on the edge that samples the last bit; no backpressure, rx_en low aborts.
module spi_rxc (
   input  logic        sclk_rx,
   input  logic        spi_rx_rstn,
   input  logic        rx_en,
   input  logic        shift_in,
   input  logic [1:0]  df,
   input  logic        lsbf,
   input  logic        crc_en,
   input  logic [12:0] spi_rnum_max,
   input  logic [31:0] crc_poly,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   output logic        rx_crc_frame,
   output logic        crc_err,
   output logic        rx_busy,
   output logic [31:0] rx_crc_data_out
);

   logic [4:0]  bit_cnt;
   logic [12:0] frame_cnt;
   logic [31:0] crc;
   logic [31:0] acc;

   logic [4:0]  last_idx;
   logic [4:0]  pos;
   logic [31:0] mask;
   logic [31:0] acc_next;
   logic [31:0] crc_next;
   logic        last_bit;
   logic        crc_frame;
   logic        fb;

   always_comb begin
      last_idx = 5'd31;
      mask     = 32'hFFFF_FFFF;
      case (df)
         2'b00: begin
            last_idx = 5'd7;
            mask     = 32'h0000_00FF;
         end
         2'b01: begin
            last_idx = 5'd15;
            mask     = 32'h0000_FFFF;
         end
         default: begin
            last_idx = 5'd31;
            mask     = 32'hFFFF_FFFF;
         end
      endcase
      last_bit  = (bit_cnt == last_idx);
      pos       = lsbf ? bit_cnt : (last_idx - bit_cnt);
      // first bit of a frame starts from a clean accumulator so upper bits stay zero
      acc_next  = (bit_cnt == 5'd0) ? 32'h0 : acc;
      acc_next[pos] = shift_in;
      // frame_cnt counts completed frames, so the frame in flight is the CRC frame once it reaches the max
      crc_frame = crc_en && (frame_cnt == spi_rnum_max);
      fb        = crc[last_idx] ^ shift_in;
      crc_next  = ((crc << 1) ^ (fb ? crc_poly : 32'h0)) & mask;
   end

   always_ff @(posedge sclk_rx) begin
      if (!spi_rx_rstn) begin
         bit_cnt      <= 5'd0;
         frame_cnt    <= 13'd0;
         crc          <= 32'h0;
         acc          <= 32'h0;
         rx_data      <= 32'h0;
         rx_valid     <= 1'b0;
         rx_crc_frame <= 1'b0;
         crc_err      <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_crc_frame <= 1'b0;
         if (!rx_en) begin
            bit_cnt   <= 5'd0;
            frame_cnt <= 13'd0;
            crc       <= 32'h0;
         end else begin
            bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
            acc     <= acc_next;
            if (crc_en && !crc_frame) begin
               crc <= crc_next;
            end
            if (last_bit) begin
               rx_data  <= acc_next;
               rx_valid <= 1'b1;
               if (crc_en) begin
                  if (crc_frame) begin
                     // compare against the CRC held before this frame; then start a new block
                     rx_crc_frame <= 1'b1;
                     if (acc_next != crc) begin
                        crc_err <= 1'b1;
                     end
                     frame_cnt <= 13'd0;
                     crc       <= 32'h0;
                  end else begin
                     frame_cnt <= frame_cnt + 13'd1;
                  end
               end
            end
         end
         if (!crc_en) begin
            frame_cnt <= 13'd0;
            crc       <= 32'h0;
            crc_err   <= 1'b0;
         end
      end
   end

   assign rx_busy         = (bit_cnt != 5'd0);
   assign rx_crc_data_out = crc;

endmodule

// File: doc/spi_rxc.md
SPI_RXC -- requirements
Module: spi_rxc

Interface
REQ-001 The block SHALL have one clock, sclk_rx; reset spi_rx_rstn is synchronous and active-low.
REQ-002 The ports SHALL be, in order:
- sclk_rx  in  1  receive shift clock
- spi_rx_rstn  in  1  synchronous active-low reset
- rx_en  in  1  receive enable; low aborts the frame and holds counters at 0
- shift_in  in  1  serial input (master: miso; slave: mosi)
- df  in  2  frame width: 00=8, 01=16, 10/11=32 bits (N)
- lsbf  in  1  1 = first wire bit is the LSB; 0 = first wire bit is the MSB
- crc_en  in  1  CRC mode enable
- spi_rnum_max  in  13  number of data frames before the CRC frame
- crc_poly  in  32  CRC polynomial; low N bits are used
- rx_data  out  32  received frame, right-justified, upper bits 0
- rx_valid  out  1  one-cycle pulse when rx_data updates
- rx_crc_frame  out  1  qualifies rx_valid: this frame is the CRC frame
- crc_err  out  1  sticky CRC mismatch flag
- rx_busy  out  1  a frame is partially received
- rx_crc_data_out  out  32  running CRC, upper bits 0

Function
REQ-003 bit_cnt (5 bits) SHALL advance by 1 on every sclk_rx edge with rx_en=1 and wrap to 0 after N-1.
REQ-004 Each such edge SHALL sample shift_in as wire bit k = bit_cnt.
REQ-005 With lsbf=1, wire bit k SHALL land in rx_data[k]; with lsbf=0 it SHALL land in rx_data[N-1-k]; bits 31:N SHALL be 0.
REQ-006 On the edge that samples bit N-1, rx_data SHALL be loaded and rx_valid SHALL be 1 for exactly the next cycle; rx_data SHALL hold until the next frame completes.
REQ-007 rx_busy SHALL equal (bit_cnt != 0).
REQ-008 Serial CRC (width N, init 0), per sampled data bit b: fb = crc[N-1]^b; crc = {crc[N-2:0],0} ^ (fb ? crc_poly[N-1:0] : 0).
REQ-009 CRC SHALL be updated on data-frame bits only, never on CRC-frame bits.
REQ-010 With crc_en=1, a 13-bit frame counter SHALL count completed frames; frames 1..spi_rnum_max are data and frame spi_rnum_max+1 is the CRC frame.
REQ-011 With spi_rnum_max=0, every frame SHALL be a CRC frame, checked against CRC 0.
REQ-012 On CRC-frame completion, rx_crc_frame SHALL pulse with rx_valid.
REQ-013 On CRC-frame completion, crc_err SHALL be set if rx_data[N-1:0] != the CRC value in force before the CRC frame.
REQ-014 After CRC-frame completion, the frame counter and CRC register SHALL return to 0 and a new block SHALL begin.
REQ-015 With crc_en=0, the frame counter, CRC register, rx_crc_frame and crc_err SHALL be held at 0, and all frames SHALL be data frames.
REQ-016 rx_en=0 SHALL clear bit_cnt, the frame counter and the CRC register in the same cycle; rx_data and crc_err SHALL be retained.
REQ-017 A partial frame in progress when rx_en falls SHALL be discarded, and no rx_valid SHALL be produced for it.
REQ-018 df, lsbf, crc_poly and spi_rnum_max SHALL only change while rx_en=0; behaviour otherwise is undefined.
REQ-019 rx_crc_data_out SHALL show the CRC register live, zero-extended.

Reset
REQ-020 With spi_rx_rstn=0 at a sclk_rx edge, all state SHALL clear: rx_data=0, rx_valid=0, rx_crc_frame=0, crc_err=0, rx_busy=0, rx_crc_data_out=0, bit_cnt=0, frame counter=0.
REQ-021 Reset SHALL take priority over rx_en.
REQ-022 Reset mid-frame SHALL discard the partial frame.

Verification
REQ-023 df=00, lsbf=0, crc_en=0, wire bits 1,0,1,0,0,1,0,1 -> rx_data=0x000000A5, rx_valid high 1 cycle after the 8th edge.
REQ-024 Same wire bits with lsbf=1 -> rx_data=0x000000A5; wire 1,1,0,0,0,0,0,0 with lsbf=1 -> rx_data=0x03.
REQ-025 df=00, lsbf=0, crc_en=1, spi_rnum_max=1, crc_poly=0x07, frames 0x01 then 0x07 -> second rx_valid with rx_crc_frame=1, crc_err=0; CRC counter back to 0.
REQ-026 As REQ-025 but second frame 0x06 -> crc_err=1 and sticky until crc_en=0.
REQ-027 df=10, send 16 bits then drop rx_en for 1 cycle, then send 32 bits 0xDEADBEEF MSB-first -> exactly one rx_valid, with rx_data=0xDEADBEEF.
REQ-028 Assert spi_rx_rstn=0 after bit 5 of a df=01 frame -> all outputs 0; the next full 16-bit frame is received correctly.
